// File: rtl/risc_ctrl_seq.sv
// Multi-cycle control sequencer for the 32-bit non-pipelined RISC datapath.
// Optional build macro: RISC_CTRL_ILLEGAL_TRAP_EN (opcodes 10..15 trap to HALT instead of acting as NOP).
module risc_ctrl_seq #(
    parameter int INSTR_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [3:0]             opcode,
    input  logic                   srctype,
    input  logic                   dsttype,
    input  logic [3:0]             ccode,
    input  logic [4:0]             psr,
    input  logic                   mem_ack,
    input  logic                   alu_done,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [1:0]             mem_asel,
    output logic                   ir_load,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   alu_start,
    output logic                   rf_we,
    output logic [1:0]             rf_wsel,
    output logic                   psr_we,
    output logic                   halted,
    output logic                   illegal,
    output logic [2:0]             state,
    output logic [INSTR_CNT_W-1:0] instr_count
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_BRA = 4'd1;
    localparam logic [3:0] OP_LD  = 4'd2;
    localparam logic [3:0] OP_STR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_MUL = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_SHF = 4'd7;
    localparam logic [3:0] OP_ROT = 4'd8;
    localparam logic [3:0] OP_HLT = 4'd9;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_IMM = 2'd1;
    localparam logic [1:0] WSEL_MEM = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t     st;
    logic       mem_rd;     // MEM phase is a load read (otherwise a write)
    logic [1:0] wsel_q;
    logic       halted_q;
    logic       op_alu;
    logic       op_multi;
    logic       op_bad;
    logic       bra_taken;
    logic       retire;

    // psr = {NEG, ZERO, PARITY, EVEN, CARRY}
    always_comb begin
        op_alu   = opcode inside {OP_ADD, OP_MUL, OP_CMP, OP_SHF, OP_ROT};
        op_multi = (opcode == OP_MUL) || (opcode == OP_ROT);
        op_bad   = (opcode > OP_HLT);
        case (ccode)
            4'd0:    bra_taken = 1'b1;
            4'd1:    bra_taken = psr[0];
            4'd2:    bra_taken = psr[1];
            4'd3:    bra_taken = psr[2];
            4'd4:    bra_taken = psr[3];
            4'd5:    bra_taken = psr[4];
            default: bra_taken = 1'b0;
        endcase
    end

    // Outputs decode from the registered state plus live handshake inputs,
    // so a zero-wait ack completes a phase in the same cycle as the request.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_asel  = 2'd0;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        alu_start = 1'b0;
        rf_we     = 1'b0;
        rf_wsel   = 2'd0;
        psr_we    = 1'b0;
        retire    = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
                pc_inc  = mem_ack;
            end
            S_DECODE: begin
                if (opcode == OP_NOP) begin
                    retire = 1'b1;
                end else if (opcode == OP_BRA) begin
                    pc_load = bra_taken;
                    retire  = 1'b1;
                end else if (op_alu) begin
                    alu_start = 1'b1;
`ifndef RISC_CTRL_ILLEGAL_TRAP_EN
                end else if (op_bad) begin
                    retire = 1'b1;
`endif
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = ~mem_rd;
                mem_asel = mem_rd ? 2'd1 : 2'd2;
                if (mem_ack && !mem_rd) begin
                    psr_we = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WRITE: begin
                rf_we   = 1'b1;
                rf_wsel = wsel_q;
                psr_we  = 1'b1;
                retire  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st          <= S_IDLE;
            mem_rd      <= 1'b0;
            wsel_q      <= WSEL_ALU;
            halted_q    <= 1'b0;
            instr_count <= '0;
        end else begin
            if (retire)
                instr_count <= instr_count + {{(INSTR_CNT_W-1){1'b0}}, 1'b1};
            case (st)
                S_IDLE:  st <= S_FETCH;
                S_FETCH: if (mem_ack) st <= S_DECODE;
                S_DECODE: begin
                    st <= S_FETCH;
                    if (opcode == OP_LD) begin
                        if (srctype) begin
                            wsel_q <= WSEL_IMM;
                            st     <= S_WRITE;
                        end else begin
                            mem_rd <= 1'b1;
                            st     <= S_MEM;
                        end
                    end else if (opcode == OP_STR) begin
                        mem_rd <= 1'b0;
                        st     <= S_MEM;
                    end else if (op_alu) begin
                        st <= S_EXEC;
                    end else if (opcode == OP_HLT) begin
                        halted_q <= 1'b1;
                        st       <= S_HALT;
`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
                    end else if (op_bad) begin
                        halted_q <= 1'b1;
                        st       <= S_HALT;
`endif
                    end
                end
                S_EXEC: begin
                    if (!op_multi || alu_done) begin
                        if (dsttype) begin
                            mem_rd <= 1'b0;
                            st     <= S_MEM;
                        end else begin
                            wsel_q <= WSEL_ALU;
                            st     <= S_WRITE;
                        end
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (mem_rd) begin
                            wsel_q <= WSEL_MEM;
                            st     <= S_WRITE;
                        end else begin
                            st <= S_FETCH;
                        end
                    end
                end
                S_WRITE: st <= S_FETCH;
                S_HALT:  st <= S_HALT;
                default: st <= S_IDLE;
            endcase
        end
    end

`ifdef RISC_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            illegal_q <= 1'b0;
        else if (st == S_DECODE && op_bad)
            illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign halted = halted_q;
    assign state  = st;

endmodule

// File: doc/risc_ctrl_seq.md
# risc_ctrl_seq

Multi-cycle control sequencer for the 32-bit non-pipelined RISC datapath (register file, ALU, PSR, PC, single-port memory). It walks each instruction through fetch, decode, execute, memory and write phases, and drives one-cycle enables plus operand/address selects into the datapath. It performs the memory request/acknowledge handshake and waits on multi-cycle ALU operations (MUL, ROT). It also keeps a retired-instruction counter for debug.

## Interface
- `INSTR_CNT_W`, 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `opcode` in 4: IR[31:28].
- `srctype` in 1: IR[27]; 0 = reg (mem for LD), 1 = immediate.
- `dsttype` in 1: IR[26]; 0 = register, 1 = memory.
- `ccode` in 4: IR[27:24].
- `psr` in 5: {NEG, ZERO, PARITY, EVEN, CARRY}.
- `mem_ack` in 1: memory transfer complete; sampled only while `mem_req`=1.
- `alu_done` in 1: multi-cycle ALU result valid.
- `mem_req`, `mem_we` out 1: memory request and write strobe.
- `mem_asel` out 2: address select; 0 = PC, 1 = SRC field, 2 = DST field.
- `ir_load`, `pc_inc`, `pc_load` out 1: single-cycle datapath pulses.
- `alu_start` out 1: single-cycle pulse launching the ALU op.
- `rf_we` out 1, `rf_wsel` out 2: register write; 0 = ALU result, 1 = immediate SRC, 2 = memory data.
- `psr_we` out 1: latch condition codes; the datapath clears and recomputes the PSR.
- `halted`, `illegal` out 1: sticky status flags.
- `state` out 3: current FSM state for debug.
- `instr_count` out INSTR_CNT_W: number of retired instructions.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WRITE=5, HALT=6.
- IDLE: entered from reset. Moves to FETCH on the next cycle.
- FETCH: drives `mem_req`=1, `mem_we`=0, `mem_asel`=0. On `mem_ack` it pulses `ir_load` and `pc_inc`, then goes to DECODE.
- DECODE, by opcode:
  - NOP: retire, go to FETCH.
  - BRA: evaluate the condition; if taken, pulse `pc_load`. Retire, go to FETCH.
    - ccode 0 = always, 1 = CARRY, 2 = EVEN, 3 = PARITY, 4 = ZERO, 5 = NEG, 6..15 = never taken.
  - LD with srctype=1: go to WRITE with `rf_wsel`=1.
  - LD with srctype=0: go to MEM, read, `mem_asel`=1.
  - STR: go to MEM, write, `mem_asel`=2.
  - ADD, MUL, CMP, SHF, ROT: pulse `alu_start`, go to EXEC.
  - HLT: go to HALT.
  - opcodes 10..15: see Configuration.
- EXEC:
  - ADD, CMP and SHF complete in one cycle.
  - MUL and ROT hold EXEC until `alu_done`.
  - When done: if dsttype=0, go to WRITE with `rf_wsel`=0; if dsttype=1, go to MEM (write, `mem_asel`=2).
- MEM: holds `mem_req` until `mem_ack`.
  - LD read: on ack go to WRITE with `rf_wsel`=2.
  - STR, or ALU result to memory: on ack pulse `psr_we`, retire, go to FETCH.
- WRITE: pulses `rf_we` and `psr_we` together, retires the instruction, goes to FETCH.
- HALT: `halted`=1. All enables and requests are 0. Only reset leaves HALT.
- Retire means `instr_count` increments by 1. The counter wraps from all-ones to 0. HLT and illegal opcodes do not retire.
- Every enable output is a single-cycle pulse, except `mem_req`, which is a level held until acknowledged.

## Timing
- Reset values: `state`=IDLE, `instr_count`=0, `halted`=0, `illegal`=0. All other outputs are 0.
- Outputs are decoded from registered state and inputs. `mem_req` is asserted in the first cycle of FETCH or MEM.
- With a zero-wait memory (ack in the same cycle as req), instruction lengths are:
  - NOP and BRA: 2 cycles.
  - LD immediate: 3 cycles.
  - LD from memory: 4 cycles.
  - STR: 3 cycles.
  - ADD to register: 4 cycles.
  - MUL: 4 + N cycles, where N is the number of cycles `alu_done` stays low after `alu_start`.
- `mem_ack` is ignored while `mem_req`=0. `alu_done` is ignored outside EXEC.
- Asserting `reset_n` low in any state, including mid-handshake, forces IDLE immediately and drops `mem_req`. A pending ack is not honoured.
- The BRA condition is evaluated on `psr` as sampled in DECODE. PSR updates from the previous instruction are therefore visible.

## Configuration
- `RISC_CTRL_ILLEGAL_TRAP_EN` defined:
  - Opcodes 10..15 set sticky `illegal`=1 and `halted`=1 and enter HALT from DECODE.
- Not defined:
  - Opcodes 10..15 behave as NOP and retire.
  - `illegal` is tied to 0.

## Test plan
- Reset, then NOP, NOP, HLT with a zero-wait memory → states 0,1,2,1,2,1,2,6; `instr_count`=2; `halted`=1.
- BRA with ccode=4 and psr=5'b01000, then ccode=4 and psr=0 → first: `pc_load` pulse; second: no `pc_load`; `instr_count`=2.
- LD from memory with `mem_ack` delayed 3 cycles → `mem_req` held 4 cycles in MEM; then one `rf_we` pulse with `rf_wsel`=2, together with `psr_we`.
- MUL with dsttype=0 and `alu_done` after 5 cycles → `alu_start` single pulse; EXEC for 6 cycles; then WRITE with `rf_we`=1 and `rf_wsel`=0.
- ADD with dsttype=1 → EXEC, then MEM with `mem_we`=1 and `mem_asel`=2; on ack `psr_we` pulses; no `rf_we` pulse.
- `reset_n` pulled low in MEM while `mem_req`=1 → `state`=0 and `mem_req`=0 asynchronously; `instr_count`=0. Opcode 12 with the macro defined → `illegal`=1, HALT; without the macro → counted as NOP.
